// File: rtl/l1_cache_if.sv
// CPU word port and physical-memory line port of one L1 cache instance.
// slave is the cache view; master is the CPU plus memory environment.
interface l1_cache_if;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;

    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    // CPU side: the request is level-held and stable until mem_resp is seen high
    // for one cycle. Memory side: pmem_read/pmem_write stay high with a stable
    // address until a single-cycle pmem_resp pulse completes the line transfer.
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 32-byte lines.
// Hits respond combinationally; misses write back a dirty victim, then fill.
module l1_cache #(
    parameter int S_INDEX = 3
) (
    input  logic       clk,
    input  logic       rst,
    l1_cache_if.slave  bus,
    output logic [1:0] dbg_state
);
    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]    valid;
    logic [SETS-1:0]    dirty;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [255:0]       data_arr [SETS];

    logic [S_INDEX-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         word_sel;
    logic               req;
    logic               hit;
    logic               write_hit;
    logic               fill_done;
    logic [255:0]       merged_line;

    // Line address captured at the miss so pmem_* stay stable for the whole
    // transaction even if the CPU withdraws or changes its request.
    logic [26:0]        miss_line;
    logic [S_INDEX-1:0] miss_index;
    logic [TAG_W-1:0]   miss_tag;
    logic               unused_addr_bits;

    assign req_index        = bus.mem_address[4+S_INDEX:5];
    assign req_tag          = bus.mem_address[31:5+S_INDEX];
    assign word_sel         = bus.mem_address[4:2];
    assign unused_addr_bits = ^bus.mem_address[1:0];
    assign miss_index       = miss_line[S_INDEX-1:0];
    assign miss_tag         = miss_line[26:S_INDEX];

    assign req       = bus.mem_read | bus.mem_write;
    assign hit       = valid[req_index] && (tag_arr[req_index] == req_tag);
    assign write_hit = (state == IDLE) && hit && bus.mem_write;
    assign fill_done = (state == ALLOCATE) && bus.pmem_resp;

    assign bus.mem_rdata  = data_arr[req_index][{word_sel, 5'b00000} +: 32];
    assign bus.pmem_wdata = data_arr[miss_index];
    assign dbg_state      = state;

    always_comb begin
        merged_line = data_arr[req_index];
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_byte_enable[b]) begin
                merged_line[{word_sel, 2'(b), 3'b000} +: 8] = bus.mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            miss_line <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req && !hit) begin
                miss_line <= bus.mem_address[31:5];
            end
            if (write_hit) begin
                dirty[req_index] <= 1'b1;
            end
            if (state == WRITEBACK && bus.pmem_resp) begin
                dirty[miss_index] <= 1'b0;
            end
            if (fill_done) begin
                valid[miss_index] <= 1'b1;
                dirty[miss_index] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[miss_index] <= bus.pmem_rdata;
            tag_arr[miss_index]  <= miss_tag;
        end else if (write_hit) begin
            data_arr[req_index] <= merged_line;
        end
    end

    always_comb begin
        state_next       = state;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        bus.mem_resp = 1'b1;
                    end else if (valid[req_index] && dirty[req_index]) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_arr[miss_index], miss_index, 5'b00000};
                if (bus.pmem_resp) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = {miss_line, 5'b00000};
                if (bus.pmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
